// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch-entry layout used by the instruction fetch unit.
package cpu_pkg;

  // Bytes per instruction; the sequential PC step.
  localparam int unsigned INST_BYTES   = 4;
  // Instruction memory read latency in cycles (registered dout).
  localparam int unsigned IMEM_LATENCY = 1;
  // Default first fetch address after reset.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One buffered fetch result, data in the upper half, PC in the lower half.
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_buf.sv
// Two-entry program-order FIFO for fetched words. The head entry is held in a
// register so decode sees registered outputs. Flush empties it in one edge.
module ifu_fetch_buf #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic         head_valid,
  output logic [W-1:0] head_data
);

  logic [W-1:0] entry0_q;  // head
  logic [W-1:0] entry1_q;
  logic [1:0]   count_q;

  // Occupancy and entry storage; pop is only ever asserted with count_q != 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= 2'd0;
    end else if (flush) begin
      count_q  <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) entry0_q <= push_data;
          else                 entry1_q <= push_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          entry0_q <= entry1_q;
          count_q  <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            entry0_q <= entry1_q;
            entry1_q <= push_data;
          end else begin
            entry0_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != 2'd0);
  assign head_data  = entry0_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: drives word-aligned addresses into a 1-cycle-latency
// instruction memory, pairs each returned word with its PC and hands it to decode
// over valid/ready. Redirects flush everything fetched or in flight.
// Optional feature macro: IFU_FETCH_ALIGN_CHK_EN adds the fetch_misalign output.
module ifu_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned         A_WIDTH  = 32,
  parameter int unsigned         D_WIDTH  = 32,
  parameter logic [A_WIDTH-1:0]  RESET_PC = A_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [A_WIDTH-1:0] imem_addr,
  input  logic [D_WIDTH-1:0] imem_dout,
  input  logic               redirect_valid,
  input  logic [A_WIDTH-1:0] redirect_pc,
  output logic               inst_valid,
  output logic [D_WIDTH-1:0] inst_data,
  output logic [A_WIDTH-1:0] inst_pc,
  input  logic               inst_ready
`ifdef IFU_FETCH_ALIGN_CHK_EN
  ,output logic              fetch_misalign
`endif
);

  localparam int unsigned EW = D_WIDTH + A_WIDTH;

  logic [A_WIDTH-1:0] pc_q;
  logic               inflight_q;
  logic [A_WIDTH-1:0] inflight_pc_q;

  logic [1:0]    buf_count;
  logic          buf_valid;
  logic [EW-1:0] buf_head;
  logic          pop;
  logic          push;
  logic          issue;
  logic [2:0]    occupancy;

  // Credit: words that will be held or still arriving after this edge must fit in two slots.
  always_comb begin
    pop       = inst_valid & inst_ready;
    occupancy = 3'(buf_count) + 3'(inflight_q) - 3'(pop);
    issue     = !redirect_valid && (occupancy < 3'd2);
    push      = inflight_q & !redirect_valid;
  end

  // PC and in-flight tracking; redirect overrides issue, reset overrides all.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (redirect_valid) begin
      pc_q       <= {redirect_pc[A_WIDTH-1:2], 2'b00};
      inflight_q <= 1'b0;
    end else if (issue) begin
      pc_q          <= pc_q + A_WIDTH'(INST_BYTES);
      inflight_q    <= 1'b1;
      inflight_pc_q <= pc_q;
    end else begin
      inflight_q <= 1'b0;
    end
  end

  ifu_fetch_buf #(
    .W (EW)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .push_data  ({imem_dout, inflight_pc_q}),
    .pop        (pop),
    .count      (buf_count),
    .head_valid (buf_valid),
    .head_data  (buf_head)
  );

  assign imem_addr  = pc_q;
  assign inst_valid = buf_valid;
  assign inst_data  = buf_head[EW-1:A_WIDTH];
  assign inst_pc    = buf_head[A_WIDTH-1:0];

`ifdef IFU_FETCH_ALIGN_CHK_EN
  logic misalign_q;

  // One-cycle flag after a redirect to a non-word-aligned target.
  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= redirect_valid & (|redirect_pc[1:0]);
  end

  assign fetch_misalign = misalign_q;
`else
  // Low target bits are dropped silently when the alignment check is not built.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
`endif

endmodule
